wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 103 ++++++++++
 tb/tb_wb_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges ALU and load results into one register-file write port.
// Define WB_ARB_RR_EN for round-robin contention; the default build uses fixed req0 priority.
module wb_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              wb_stall,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_sel,
    output logic [7:0]        conflict_cnt
);

`ifdef WB_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              wb_en_q,   wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_sel_q,  wb_sel_d;
    logic [7:0]        cnt_q,     cnt_d;
    logic              last_grant_q, last_grant_d;

    logic slot_free;
    logic contended;
    logic pick1;

    always_comb begin
        slot_free = !wb_en_q || !wb_stall;
        contended = req0_valid && req1_valid;
        // Under contention req1 wins only in round-robin mode when req0 was served last.
        pick1 = req1_valid && (!req0_valid || (RR_EN && !last_grant_q));

        req0_ready = rst_n && slot_free && req0_valid && !pick1;
        req1_ready = rst_n && slot_free && pick1;

        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        wb_en_d      = wb_en_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_sel_d     = wb_sel_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        if (slot_free) begin
            wb_en_d = req0_ready || req1_ready;
            if (req0_ready) begin
                wb_addr_d    = req0_addr;
                wb_data_d    = req0_data;
                wb_sel_d     = 1'b0;
                last_grant_d = 1'b0;
            end else if (req1_ready) begin
                wb_addr_d    = req1_addr;
                wb_data_d    = req1_data;
                wb_sel_d     = 1'b1;
                last_grant_d = 1'b1;
            end
            if (contended && cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            wb_sel_q     <= 1'b0;
            cnt_q        <= 8'd0;
            last_grant_q <= 1'b1;
        end else begin
            wb_en_q      <= wb_en_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_sel_q     <= wb_sel_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign wb_sel       = wb_sel_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, corner-case sequences, random vs model.
// Expected arbitration follows WB_ARB_RR_EN when the bench is built with it.
module tb_wb_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;
`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, wb_addr;
    logic [DW-1:0] req0_data, req1_data, wb_data;
    logic          wb_stall, wb_en, wb_sel;
    logic [7:0]    conflict_cnt;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .wb_stall(wb_stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_sel(wb_sel),
        .conflict_cnt(conflict_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the write-back slot as plain variables plus who was served last.
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_sel;
    int            m_cnt;
    int            m_last;

    task automatic model_reset();
        m_en = 0; m_addr = '0; m_data = '0; m_sel = 0; m_cnt = 0; m_last = 1;
    endtask

    function automatic int model_winner();
        if (!rst_n || (m_en && wb_stall)) return -1;
        if (req0_valid && req1_valid) return RR ? 1 - m_last : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_clock();
        int w;
        w = model_winner();
        if (rst_n && !(m_en && wb_stall)) begin
            if (req0_valid && req1_valid && m_cnt < 255) m_cnt++;
            if (w == 0) begin
                m_en = 1; m_addr = req0_addr; m_data = req0_data; m_sel = 0; m_last = 0;
            end else if (w == 1) begin
                m_en = 1; m_addr = req1_addr; m_data = req1_data; m_sel = 1; m_last = 1;
            end else begin
                m_en = 0;
            end
        end
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_data = '0;
        wb_stall = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic          v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic          v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic          stall;
        logic [1:0]    rdy;
        logic          en; logic [AW-1:0] addr; logic [DW-1:0] data; logic sel;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0, 2'b10, 1, 3'd3, 8'h5A, 0};
        tbl[1] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 2'b00, 0, 3'd3, 8'h5A, 0};
        tbl[2] = '{0, 3'd0, 8'h00, 1, 3'd5, 8'hC3, 0, 2'b01, 1, 3'd5, 8'hC3, 1};
        tbl[3] = '{0, 3'd0, 8'h00, 1, 3'd6, 8'h77, 1, 2'b00, 1, 3'd5, 8'hC3, 1};
        tbl[4] = '{0, 3'd0, 8'h00, 1, 3'd6, 8'h77, 0, 2'b01, 1, 3'd6, 8'h77, 1};
        tbl[5] = '{1, 3'd1, 8'h0F, 0, 3'd0, 8'h00, 0, 2'b10, 1, 3'd1, 8'h0F, 0};
        tbl[6] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 2'b00, 1, 3'd1, 8'h0F, 0};
        tbl[7] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 2'b00, 0, 3'd1, 8'h0F, 0};
        tbl[8] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 2'b00, 0, 3'd1, 8'h0F, 0};
        tbl[9] = '{1, 3'd2, 8'hAA, 0, 3'd0, 8'h00, 1, 2'b10, 1, 3'd2, 8'hAA, 0};

        // Reset state, with both requesters pushing: readies must stay low.
        rst_n = 0;
        idle_inputs();
        model_reset();
        req0_valid = 1; req1_valid = 1;
        #12;
        check("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("reset_state", 32'({wb_en, wb_addr, wb_data, wb_sel, conflict_cnt}), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;

        // Vector table: first row transfers on the first edge after release.
        for (int i = 0; i < 10; i++) begin
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
            wb_stall   = tbl[i].stall;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'({req0_ready, req1_ready}), 32'(tbl[i].rdy));
            cycle();
            check($sformatf("tbl%0d_out", i), 32'({wb_en, wb_addr, wb_data, wb_sel}),
                  32'({tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].sel}));
        end
        check("tbl_cnt", 32'(conflict_cnt), 32'd0);

        // Contention for four cycles from a fresh reset.
        do_reset();
        req0_valid = 1; req0_addr = 3'd4; req0_data = 8'h40;
        req1_valid = 1; req1_addr = 3'd7; req1_data = 8'h70;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont%0d_grant", i), 32'({req0_ready, req1_ready}),
                  (RR && (i % 2 == 1)) ? 32'd1 : 32'd2);
            cycle();
            check($sformatf("cont%0d_sel", i), 32'(wb_sel), (RR && (i % 2 == 1)) ? 32'd1 : 32'd0);
        end
        check("cont_cnt", 32'(conflict_cnt), 32'd4);
        idle_inputs();
        cycle();

        // Stalled write holds while req1 waits.
        req0_valid = 1; req0_addr = 3'd1; req0_data = 8'h11;
        cycle();
        req0_valid = 0;
        wb_stall = 1;
        req1_valid = 1; req1_addr = 3'd2; req1_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_ready", i), 32'({req0_ready, req1_ready}), 32'd0);
            check($sformatf("stall%0d_out", i), 32'({wb_en, wb_data}), 32'({1'b1, 8'h11}));
            cycle();
        end
        wb_stall = 0;
        #1;
        check("unstall_ready", 32'(req1_ready), 32'd1);
        cycle();
        check("unstall_out", 32'({wb_en, wb_addr, wb_data, wb_sel}), 32'({1'b1, 3'd2, 8'h22, 1'b1}));

        // Asynchronous reset between edges while a write is stalled.
        req0_valid = 1; req0_addr = 3'd5; req0_data = 8'h99;
        wb_stall = 1;
        #2 rst_n = 0;
        #1;
        check("midrst_state", 32'({wb_en, wb_addr, wb_data, wb_sel, conflict_cnt}), 32'd0);
        check("midrst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        idle_inputs();
        model_reset();
        rst_n = 1;
        cycle();
        check("postrst_idle0", 32'(wb_en), 32'd0);
        cycle();
        check("postrst_idle1", 32'(wb_en), 32'd0);
        req1_valid = 1; req1_addr = 3'd3; req1_data = 8'h3C;
        cycle();
        check("postrst_xfer", 32'({wb_en, wb_addr, wb_data, wb_sel}), 32'({1'b1, 3'd3, 8'h3C, 1'b1}));

        // Conflict counter saturation.
        do_reset();
        req0_valid = 1; req1_valid = 1;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (i == 254) check("sat_254", 32'(conflict_cnt), 32'd254);
            if (i == 255) check("sat_255", 32'(conflict_cnt), 32'd255);
        end
        check("sat_300", 32'(conflict_cnt), 32'd255);

        // Randomized traffic against the model; requesters hold until accepted.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int w;
            #1;
            w = model_winner();
            check($sformatf("rand%0d", i),
                  32'({req0_ready, req1_ready, wb_en, wb_addr, wb_data, wb_sel, conflict_cnt}),
                  32'({w == 0, w == 1, m_en, m_addr, m_data, m_sel, 8'(m_cnt)}));
            cycle();
            if (!req0_valid || w == 0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_addr  = AW'($urandom);
                req0_data  = DW'($urandom);
            end
            if (!req1_valid || w == 1) begin
                req1_valid = ($urandom_range(0, 1) == 1);
                req1_addr  = AW'($urandom);
                req1_data  = DW'($urandom);
            end
            wb_stall = ($urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
